// File: rtl/ks_adder_arbiter_if.sv
// Requester/consumer bus of the shared-adder arbiter: per-requester operand
// handshakes plus the single tagged result channel.
interface ks_adder_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_chain;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_chain, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_chain, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/ks_adder_arbiter.sv
// One Kogge-Stone adder shared round-robin among NREQ requesters, with a
// one-deep tagged result slot and a stored carry per requester for chaining.
module KS_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  localparam int LVL = $clog2(W);

  logic [LVL:0][W-1:0] g;
  logic [LVL:0][W-1:0] p;

  always_comb begin
    g = '0;
    p = '0;
    g[0] = a_i & b_i;
    p[0] = a_i ^ b_i;
    // Fold carry-in into bit 0 so every group generate already includes it.
    g[0][0] = g[0][0] | (p[0][0] & cin_i);
    for (int l = 1; l <= LVL; l++) begin
      for (int i = 0; i < W; i++) begin
        if (i >= (1 << (l - 1))) begin
          g[l][i] = g[l-1][i] | (p[l-1][i] & g[l-1][i - (1 << (l - 1))]);
          p[l][i] = p[l-1][i] & p[l-1][i - (1 << (l - 1))];
        end else begin
          g[l][i] = g[l-1][i];
          p[l][i] = p[l-1][i];
        end
      end
    end
    sum_o  = p[0] ^ {g[LVL][W-2:0], cin_i};
    cout_o = g[LVL][W-1];
  end
endmodule

module ks_arb_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic upd_i,
  input  logic cout_i,
  input  logic cin_i,
  input  logic chain_i,
  output logic cin_o
);
  logic carry_q;

  assign cin_o = chain_i ? carry_q : cin_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     carry_q <= 1'b0;
    else if (upd_i) carry_q <= cout_i;
  end
endmodule

module ks_adder_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  ks_adder_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_found, slot_free, accept;
  logic [NREQ-1:0] gnt_oh, lane_cin, req_cin, req_chain;
  logic [W-1:0]    add_a, add_b, add_sum;
  logic            add_cin, add_cout;

  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [W-1:0]    rsp_sum_q;
  logic            rsp_cout_q;

  assign slot_free = !rsp_valid_q || bus.rsp_ready;

  // Scan from the far end back toward ptr so the nearest valid wins last.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (bus.req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(j);
      end
    end
  end

  assign accept        = gnt_found && slot_free;
  assign gnt_oh        = accept ? (NREQ'(1) << gnt_id) : '0;
  assign bus.req_ready = gnt_oh;

  assign req_cin   = bus.req_cin;
  assign req_chain = bus.req_chain;
  assign add_a     = bus.req_a[gnt_id*W +: W];
  assign add_b     = bus.req_b[gnt_id*W +: W];
  assign add_cin   = lane_cin[gnt_id];

  ks_arb_lane u_lane [NREQ-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .upd_i   (gnt_oh),
    .cout_i  (add_cout),
    .cin_i   (req_cin),
    .chain_i (req_chain),
    .cin_o   (lane_cin)
  );

  KS_adder #(.W(W)) u_add (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= gnt_id;
        rsp_sum_q   <= add_sum;
        rsp_cout_q  <= add_cout;
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
endmodule

// File: doc/ks_adder_arbiter.md
Name: ks_adder_arbiter

Overview:
- Shares one 8-bit KS_adder instance among NREQ requesters (e.g. accumulator lanes) using round-robin arbitration with valid/ready handshakes.
- Returns registered results tagged with the requester ID.
- Keeps one carry flag per requester so a requester can run multi-byte additions as a chain of 8-bit operations without holding the adder between bytes.

Parameters:
- NREQ, 4, number of requesters (2..8); ID width IDW = clog2(NREQ).
- W, 8, operand width; must equal the width of the KS_adder instance.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept. One-hot or zero.
- req_a  in  NREQ*W  packed operand A; requester i uses bits [i*W +: W].
- req_b  in  NREQ*W  packed operand B, same packing as req_a.
- req_cin  in  NREQ  explicit carry-in, used when the matching req_chain bit is 0.
- req_chain  in  NREQ  1 = use the stored carry of that requester instead of req_cin.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_sum  out  W  sum bits.
- rsp_cout  out  1  carry-out.

Behaviour:
- Reset (async assert, sync release):
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, req_ready=0.
  - Round-robin pointer=0; all stored carries=0.
- Output slot is one deep. slot_free = !rsp_valid || rsp_ready.
- Grant:
  - Only when slot_free, to the first requester with req_valid=1, searching from index ptr upward and wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in that cycle. All other req_ready bits are 0.
  - If slot_free=0, all req_ready bits are 0.
- Accept = req_valid[g] && req_ready[g]. Adder inputs are the granted requester's A and B.
- Carry-in:
  - req_chain[g] ? carry_q[g] : req_cin[g].
  - carry_q[g] is reset/initial 0, so a chained op issued first after reset uses cin=0.
- On accept, at the next rising edge:
  - rsp_valid=1, rsp_sum=S, rsp_cout=Cout, rsp_id=g.
  - carry_q[g] is updated to Cout.
  - ptr is updated to (g+1) mod NREQ.
  - Latency: accept to rsp_valid is exactly 1 cycle.
- If rsp_valid && rsp_ready and there is no accept in the same cycle, rsp_valid becomes 0 at the next edge. Data outputs hold their values.
- Drain and accept in the same cycle: the new result replaces the old one. rsp_valid stays 1. Throughput is 1 op/cycle with no bubble.
- Backpressure: while rsp_valid && !rsp_ready:
  - rsp_* are held stable.
  - No grants are made, and ptr and carry_q are unchanged.
- No accept in a cycle leaves ptr and all carry_q values unchanged. Requesters that are not granted keep their stored carries.
- Width: full sum is W+1 bits = {rsp_cout, rsp_sum}, equal to A+B+cin exactly. No saturation.
- Requester inputs must be held stable while req_valid=1 && !req_ready. The arbiter does not register unaccepted requests.
- rst_n asserted mid-operation: any pending result is discarded and carry chains are cleared immediately. Requesters must reissue.

Test Plan:
- Single op: req_valid=0001, A0=0xFF, B0=0x01, cin=1, chain=0 -> ready[0]=1 in the same cycle. Next cycle rsp_valid=1, id=0, sum=0x01, cout=1.
- Round-robin: all 4 valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles. rsp_valid stays high with no bubbles.
- Chained 16-bit add, requester 2: 0x12FF+0x0101 issued as low byte (FF+01, chain=0), then high byte (12+01, chain=1) -> sums 0x00 with cout=1, then 0x14 with cout=0.
- Chain isolation: requester 1 gets cout=1 and requester 3 gets cout=0, interleaved; then a chained op from requester 3 with A=B=0 -> sum=0x00. A chained op from requester 1 with A=B=0 -> sum=0x01.
- Backpressure: rsp_ready=0 for 3 cycles with requests pending -> req_ready=0, rsp_* unchanged, ptr frozen. Raise rsp_ready -> the next grant follows from the held ptr.
- Reset mid-stream: drop rst_n while rsp_valid=1 with carry_q[0]=1 -> outputs go to 0 asynchronously. After release, a chained op from requester 0 with A=B=0x00 -> sum=0x00.
- Random: 1000 ops with random valid/chain/rsp_ready patterns -> each {cout,sum} equals A+B+cin from a reference model tracking per-requester carries.
